uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Bus initiator that turns a UART receive byte stream into 32-bit transactions on the native picorv32 memory bus, and returns results as a transmit byte stream. It drives the same bus that the core uses toward sysmem and the UART register block. It is used for debug peek/poke and for program loading while the core is held in reset. Read responses and write acknowledgements go back over a UART transmit byte interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles a bus request may wait for mem_ready; used only with UBM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (pll_sys_clk at top level).
- resetn  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte on tx_valid && tx_ready.
- mem_valid  out  1  bus request.
- mem_instr  out  1  constant 0.
- mem_ready  in  1  responder completes the request.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for a write, 4'h0 for a read.
- mem_rdata  in  32  read data; sampled when mem_ready is high.
- busy  out  1  high in every state except IDLE.

## Operation
- Commands: 0x57 'W' followed by addr[4 bytes LE] and data[4 bytes LE]; 0x52 'R' followed by addr[4 bytes LE].
- Responses:
  - Write: one byte, 0x4B 'K'.
  - Read: 4 data bytes, LE.
  - Unknown command byte: one byte, 0x3F '?'; the block then returns to IDLE.
- FSM states: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: on rx_valid, latch the command. 'W' or 'R' → ADDR. Other values → RESP with '?'.
  - ADDR: shift 4 bytes into the address register, low byte first. After the 4th byte, 'W' → DATA and 'R' → BUS.
  - DATA: shift 4 bytes into wdata. After the 4th byte → BUS.
  - BUS: mem_valid is high. Leave BUS in the cycle mem_ready is sampled high; on a read, mem_rdata is captured in that cycle. → RESP.
  - RESP: send the response bytes one per tx handshake. After the last accepted byte → IDLE.
- Received bytes:
  - rx_valid in BUS or RESP: the byte is dropped. No error is reported.
  - Address bytes: received addr[1:0] is discarded, so the bus address is always word-aligned.
- Byte counter: 2 bits. Reset to 0 on every state entry. Wraps from 3 to 0 only on a state transition.

## Timing
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, mem_instr=0, tx_valid=0, tx_data=0, busy=0. The FSM resets to IDLE.
- mem_valid rises on the clock edge after the final command byte is captured.
- mem_addr, mem_wdata and mem_wstrb are stable for the whole time mem_valid is high.
- mem_valid falls on the edge after mem_ready is sampled high.
- mem_ready sampled high in the same cycle mem_valid first rises completes the transfer in 1 cycle.
- tx_valid rises on the edge after the FSM enters RESP.
- tx_data changes only after a handshake. Between bytes tx_valid stays high (no bubble).
- Minimum transaction turnaround:
  - Write: 9 rx bytes + 1 bus cycle + 1 tx byte.
  - Read: 5 rx bytes + 1 bus cycle + 4 tx bytes.
- Reset mid-transaction: the block is in IDLE on the next edge. mem_valid and tx_valid drop regardless of mem_ready or tx_ready. A partial command is discarded.
- mem_ready asserted while mem_valid is low: ignored.

## Configuration
- UBM_TIMEOUT_EN defined:
  - A cycle counter clears when BUS is entered and increments on each cycle with mem_valid && !mem_ready.
  - If it reaches TIMEOUT_CYCLES-1 with mem_ready still low: mem_valid drops on the next edge, and the block responds with the single byte 0x54 'T' for both R and W. For a read, no data bytes are sent.
  - mem_ready arriving in the same cycle as the terminal count wins; the transfer completes normally.
- UBM_TIMEOUT_EN undefined: BUS waits indefinitely. No counter logic is present, and 'T' is never sent.

## Structure
- Shared package ubm_pkg holds:
  - command codes CMD_WR=8'h57 and CMD_RD=8'h52;
  - response codes RSP_OK=8'h4B, RSP_ERR=8'h3F and RSP_TO=8'h54;
  - the state encoding for IDLE/ADDR/DATA/BUS/RESP.
- One sub-module, ubm_timeout: the timeout counter, with inputs clk, resetn, clr and run and output expired. It is instantiated only under UBM_TIMEOUT_EN.
- The shift registers and the FSM stay inline.

## Test plan
- Write: rx 57 00 01 00 00 EF BE AD DE → one bus write with mem_addr=0x00000100, mem_wdata=0xDEADBEEF, mem_wstrb=F. mem_ready given after 3 wait cycles → tx 4B.
- Read: rx 52 03 01 00 00; responder returns 0x12345678 with a 0-wait mem_ready → mem_addr=0x00000100, mem_wstrb=0, tx 78 56 34 12. Hold tx_ready low 5 cycles before the 2nd byte → tx_data stays 56 with tx_valid high.
- Unknown command: rx 41 → tx 3F with no bus activity. A following 52 … read then completes normally.
- Dropped bytes: inject rx bytes during BUS and during RESP → they are ignored, and the next command decodes correctly.
- Reset mid-transaction: assert resetn low while in BUS with mem_ready low → next edge has mem_valid=0, busy=0, tx_valid=0.
- Timeout (UBM_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with mem_ready never asserted → mem_valid high for 16 cycles, then tx 54 only.

Source files
------------

// File: rtl/ubm_pkg.sv
// Shared codes and FSM state type for the UART bus master.
package ubm_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;
   localparam logic [7:0] RSP_TO  = 8'h54;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

endpackage

// File: rtl/ubm_timeout.sv
// Bus wait counter: flags expiry when a stalled request reaches TIMEOUT_CYCLES-1.
module ubm_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!resetn || clr)
         count <= '0;
      else if (run && !expired)
         count <= count + W'(1);
   end

   assign expired = run && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_bus_master.sv
// UART byte stream to picorv32 native bus initiator (peek/poke, program load).
// Optional bus timeout with 'T' response when UBM_TIMEOUT_EN is defined.
module uart_bus_master
   import ubm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   state_t      state, state_next;
   logic [1:0]  cnt;
   logic [7:0]  cmd;
   logic [29:0] addr_q;
   logic [31:0] wdata;
   logic [31:0] tx_shift;
   logic [1:0]  rsp_last;
   logic        advance;
   logic        expired;

`ifdef UBM_TIMEOUT_EN
   ubm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (state != BUS),
      .run     (mem_valid && !mem_ready),
      .expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign expired = 1'b0;
`endif

   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         IDLE: if (rx_valid)
            state_next = (rx_data == CMD_WR || rx_data == CMD_RD) ? ADDR : RESP;
         ADDR: begin
            advance = rx_valid;
            if (rx_valid && cnt == 2'd3)
               state_next = (cmd == CMD_WR) ? DATA : BUS;
         end
         DATA: begin
            advance = rx_valid;
            if (rx_valid && cnt == 2'd3)
               state_next = BUS;
         end
         BUS: if (mem_ready || expired)
            state_next = RESP;
         RESP: begin
            advance = tx_ready;
            if (tx_ready && cnt == rsp_last)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= '0;
         cmd      <= '0;
         addr_q   <= '0;
         wdata    <= '0;
         tx_shift <= '0;
         rsp_last <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            cnt <= '0;
         else if (advance)
            cnt <= cnt + 2'd1;
         case (state)
            IDLE: if (rx_valid) begin
               cmd      <= rx_data;
               tx_shift <= {24'h0, RSP_ERR};
               rsp_last <= 2'd0;
            end
            // addr_q holds addr[31:2]; the two low bits of byte 0 shift out
            ADDR: if (rx_valid) addr_q <= {rx_data, addr_q[29:8]};
            DATA: if (rx_valid) wdata <= {rx_data, wdata[31:8]};
            BUS: begin
               if (mem_ready) begin
                  tx_shift <= (cmd == CMD_WR) ? {24'h0, RSP_OK} : mem_rdata;
                  rsp_last <= (cmd == CMD_WR) ? 2'd0 : 2'd3;
               end else if (expired) begin
                  tx_shift <= {24'h0, RSP_TO};
                  rsp_last <= 2'd0;
               end
            end
            RESP: if (tx_ready) tx_shift <= {8'h00, tx_shift[31:8]};
            default: ;
         endcase
      end
   end

   assign mem_valid = (state == BUS);
   assign mem_instr = 1'b0;
   assign mem_addr  = {addr_q, 2'b00};
   assign mem_wdata = wdata;
   assign mem_wstrb = (state == BUS && cmd == CMD_WR) ? 4'hF : 4'h0;
   assign tx_valid  = (state == RESP);
   assign tx_data   = (state == RESP) ? tx_shift[7:0] : 8'h00;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed plus randomized bench for uart_bus_master with a word-memory reference model.
module tb_uart_bus_master;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          spurious = 1'b0;
   logic [31:0] model [logic [29:0]];

   uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data   = b;
      rx_valid  = 1'b1;
      mem_ready = spurious;
      @(negedge clk);
      rx_valid  = 1'b0;
      rx_data   = 8'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF));
   endtask

   // bus responder; entered at the negedge right after the final command byte
   task automatic do_bus(input logic [31:0] a, input logic [31:0] d, input bit is_wr,
                         input int unsigned waits, input logic [31:0] rdata, input bit inject);
      logic [31:0] exp_addr;
      exp_addr = a & 32'hFFFF_FFFC;
      check("bus_valid_rise", 32'(mem_valid), 32'd1);
      check("bus_addr", mem_addr, exp_addr);
      check("bus_wstrb", 32'(mem_wstrb), is_wr ? 32'hF : 32'h0);
      check("bus_instr", 32'(mem_instr), 32'd0);
      if (is_wr) check("bus_wdata", mem_wdata, d);
      mem_ready = 1'b0;
      for (int unsigned w = 0; w < waits; w++) begin
         if (inject) begin
            rx_valid = 1'b1;
            rx_data  = 8'h52;
         end
         @(negedge clk);
         rx_valid = 1'b0;
         check("bus_valid_hold", 32'(mem_valid), 32'd1);
         check("bus_addr_hold", mem_addr, exp_addr);
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      check("bus_valid_fall", 32'(mem_valid), 32'd0);
   endtask

   task automatic get_tx(input logic [7:0] exp, input int unsigned stall, input bit inject,
                         input bit last);
      int unsigned n = 0;
      while (tx_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("tx_valid", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(exp));
      for (int unsigned s = 0; s < stall; s++) begin
         if (inject) begin
            rx_valid = 1'b1;
            rx_data  = 8'h57;
         end
         @(negedge clk);
         rx_valid = 1'b0;
         check("tx_stall_valid", 32'(tx_valid), 32'd1);
         check("tx_stall_data", 32'(tx_data), 32'(exp));
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      if (last) begin
         check("tx_done_valid", 32'(tx_valid), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end else begin
         check("tx_no_bubble", 32'(tx_valid), 32'd1);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int unsigned waits,
                           input bit inject, input int unsigned stall);
      send_byte(8'h57);
      send_word(a);
      send_word(d);
      do_bus(a, d, 1'b1, waits, $urandom, inject);
      model[a[31:2]] = d;
      get_tx(8'h4B, stall, inject, 1'b1);
   endtask

   task automatic do_read(input logic [31:0] a, input int unsigned waits, input logic [31:0] rdata,
                          input bit inject, input int unsigned stall2);
      send_byte(8'h52);
      send_word(a);
      do_bus(a, 32'h0, 1'b0, waits, rdata, inject);
      for (int i = 0; i < 4; i++)
         get_tx(8'((rdata >> (8 * i)) & 32'hFF), (i == 1) ? stall2 : 0, inject, i == 3);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [7:0]  b;
      int unsigned n;
      resetn    = 1'b0;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      tx_ready  = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst_mem_instr", 32'(mem_instr), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      do_write(32'h0000_0100, 32'hDEAD_BEEF, 3, 1'b0, 0);
      do_read(32'h0000_0103, 0, 32'h1234_5678, 1'b0, 5);

      send_byte(8'h41);
      check("unk_no_bus", 32'(mem_valid), 32'd0);
      get_tx(8'h3F, 0, 1'b0, 1'b1);
      do_read(32'h0000_0100, 1, model[30'h40], 1'b0, 0);

      do_write(32'h0000_0204, 32'hCAFE_F00D, 3, 1'b1, 2);
      model[30'h81] = 32'hCAFE_F00D;
      do_read(32'h0000_0204, 2, model[30'h81], 1'b1, 3);

      send_byte(8'h52);
      send_word(32'h0000_0300);
      check("rst_mid_bus_valid", 32'(mem_valid), 32'd1);
      mem_ready = 1'b0;
      resetn    = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

`ifdef UBM_TIMEOUT_EN
      spurious = 1'b0;
      send_byte(8'h52);
      send_word(32'h0000_0400);
      mem_ready = 1'b0;
      n = 0;
      while (mem_valid === 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      check("timeout_valid_cycles", n, 32'd16);
      get_tx(8'h54, 0, 1'b0, 1'b1);
`endif

      for (int t = 0; t < 24; t++) begin
         spurious = 1'($urandom_range(0, 1));
         a = 32'h1000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0: begin
               b = 8'($urandom);
               if (b == 8'h57 || b == 8'h52) b = 8'h00;
               send_byte(b);
               check("rnd_unk_no_bus", 32'(mem_valid), 32'd0);
               get_tx(8'h3F, $urandom_range(0, 2), 1'b1, 1'b1);
            end
            1, 2, 3, 4: begin
               d = $urandom;
               do_write(a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
            default: begin
               if (!model.exists(a[31:2])) model[a[31:2]] = $urandom;
               do_read(a, $urandom_range(0, 3), model[a[31:2]], 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3));
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
